key_debounce: RTL and testbench

- Conditions the raw elevator push-buttons (floor calls, car calls, door open/close) into clean one-cycle press pulses.
- Drives the press_call inputs of the call-latch stage directly downstream.
- Each channel is synchronised, debounced by a per-channel counter FSM, and edge-detected.
- One pulse is emitted per physical press. Bounce, glitches and held keys never re-toggle a latched call.

---
 rtl/elevator_pkg.sv | 25 ++
 rtl/key_debounce_ch.sv | 98 +++++++++
 rtl/key_debounce.sv | 40 ++++
 tb/tb_key_debounce.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator key constants: channel FSM states,
// default debounce length and key index map.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CNT   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CNT = 2'd3
  } deb_state_t;

  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int SYNC_DEFAULT     = 2;
  localparam int N_KEYS_DEFAULT   = 8;

  localparam int KEY_HALL_UP_0  = 0;
  localparam int KEY_HALL_UP_1  = 1;
  localparam int KEY_HALL_DN_1  = 2;
  localparam int KEY_HALL_DN_2  = 3;
  localparam int KEY_CAR_0      = 4;
  localparam int KEY_CAR_1      = 5;
  localparam int KEY_DOOR_OPEN  = 6;
  localparam int KEY_DOOR_CLOSE = 7;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, counter FSM, pulse/level regs.
// Ports: clk, rst, raw in; pulse, level, pulse_set (next pulse) out.
module key_debounce_ch
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level,
  output logic pulse_set
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_t             state, state_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic                   level_d;
  logic                   done;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign done = (cnt == LAST);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    level_d   = level;
    pulse_set = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = s ? ONE : '0;
        if (s) state_d = PRESS_CNT;
      end
      PRESS_CNT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (done) begin
          state_d   = PRESSED;
          pulse_set = 1'b1;
          level_d   = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_CNT;
          cnt_d   = ONE;
        end
      end
      RELEASE_CNT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (done) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      level <= level_d;
      pulse <= pulse_set;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS raw buttons into press pulses and levels.
// Ports: clk, rst, key_raw in; key_pulse, key_level, any_pulse out.
module key_debounce
  import elevator_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_pulse,
  output logic [N_KEYS-1:0] key_level,
  output logic              any_pulse
);

  logic [N_KEYS-1:0] pulse_set;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (key_raw[i]),
      .pulse    (key_pulse[i]),
      .level    (key_level[i]),
      .pulse_set(pulse_set[i])
    );
  end

  // Built from the next-pulse bits so it lands with key_pulse.
  always_ff @(posedge clk) begin
    if (rst) any_pulse <= 1'b0;
    else     any_pulse <= |pulse_set;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (4 keys, 4-cycle debounce).
// Checks latency, glitches, bounce, release, reset.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_raw;
  logic [3:0] key_pulse;
  logic [3:0] key_level;
  logic       any_pulse;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_raw),
    .key_pulse(key_pulse),
    .key_level(key_level),
    .any_pulse(any_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    key_raw = 4'b0000;
    ticks(3);
    chk("rst_pulse", 32'(key_pulse), 32'h0);
    chk("rst_level", 32'(key_level), 32'h0);
    chk("rst_any",   32'(any_pulse), 32'h0);
    rst = 1'b0;
    ticks(3);

    // clean press on key 0: pulse at E5
    key_raw[0] = 1'b1;
    ticks(5);
    chk("clean_pre_pulse", 32'(key_pulse), 32'h0);
    chk("clean_pre_level", 32'(key_level), 32'h0);
    tick();
    chk("clean_pulse", 32'(key_pulse), 32'h1);
    chk("clean_any",   32'(any_pulse), 32'h1);
    chk("clean_level", 32'(key_level), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("clean_held_pulse", 32'(key_pulse[0]), 32'h0);
      chk("clean_held_any",   32'(any_pulse),    32'h0);
    end
    chk("clean_held_level", 32'(key_level[0]), 32'h1);

    // glitch on key 1: 3 cycles high
    key_raw[1] = 1'b1;
    ticks(3);
    key_raw[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch_pulse", 32'(key_pulse[1]), 32'h0);
      chk("glitch_level", 32'(key_level[1]), 32'h0);
    end

    // bouncy press on key 2: 1,0,1,0 then steady 1
    for (int i = 0; i < 4; i++) begin
      key_raw[2] = (i % 2 == 0);
      tick();
      chk("bounce_pulse", 32'(key_pulse[2]), 32'h0);
    end
    key_raw[2] = 1'b1;
    ticks(5);
    chk("bounce_pre", 32'(key_pulse[2]), 32'h0);
    tick();
    chk("bounce_pulse1", 32'(key_pulse), 32'h4);
    chk("bounce_level",  32'(key_level[2]), 32'h1);

    // release bounce of 2 low cycles while held
    key_raw[2] = 1'b0;
    ticks(2);
    key_raw[2] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("relb_pulse", 32'(key_pulse[2]), 32'h0);
      chk("relb_level", 32'(key_level[2]), 32'h1);
    end

    // release key 0: level falls at E5
    key_raw[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rel_pulse", 32'(key_pulse[0]), 32'h0);
    end
    chk("rel_level_hi", 32'(key_level[0]), 32'h1);
    tick();
    chk("rel_level_lo", 32'(key_level[0]), 32'h0);
    chk("rel_nopulse",  32'(key_pulse[0]), 32'h0);
    ticks(3);

    // new press on key 0 after release
    key_raw[0] = 1'b1;
    ticks(5);
    chk("repress_pre", 32'(key_pulse[0]), 32'h0);
    tick();
    chk("repress_pulse", 32'(key_pulse[0]), 32'h1);

    // release everything
    key_raw = 4'b0000;
    ticks(10);
    chk("all_rel_level", 32'(key_level), 32'h0);

    // simultaneous press of all keys
    key_raw = 4'b1111;
    ticks(5);
    chk("simul_pre", 32'(key_pulse), 32'h0);
    tick();
    chk("simul_pulse", 32'(key_pulse), 32'hf);
    chk("simul_any",   32'(any_pulse), 32'h1);
    tick();
    chk("simul_after", 32'(key_pulse), 32'h0);
    chk("simul_any0",  32'(any_pulse), 32'h0);
    chk("simul_level", 32'(key_level), 32'hf);
    key_raw = 4'b0000;
    ticks(10);
    chk("simul_rel", 32'(key_level), 32'h0);

    // reset at the third counting edge, key held through it
    key_raw[0] = 1'b1;
    ticks(4);
    rst = 1'b1;
    tick();
    chk("rstmid_pulse", 32'(key_pulse), 32'h0);
    chk("rstmid_level", 32'(key_level), 32'h0);
    ticks(2);
    chk("rstmid_hold",  32'(key_level), 32'h0);
    chk("rstmid_any",   32'(any_pulse), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstrel_pre", 32'(key_pulse[0]), 32'h0);
    end
    tick();
    chk("rstrel_pulse", 32'(key_pulse[0]), 32'h1);
    chk("rstrel_level", 32'(key_level[0]), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
